iir_decimator: RTL and testbench

- Sits directly downstream of the iir_filter SOS cascade and consumes its dv_out/d_out stream.
- Keeps every Mdec-th valid sample and requantizes it from Q(Ndint.Ndfrac) to Q(Noint.Nofrac) with round-half-up and saturation.
- Buffers results in a small FIFO with a ready/valid output toward the consumer (DAC formatter / capture).

---
 rtl/iir_decimator.sv | 155 +++++++++++++++
 tb/tb_iir_decimator.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_decimator.sv
// Decimates the iir_filter output stream by Mdec, requantizes each kept sample with
// round-half-up and saturation, and buffers the results in a ready/valid FIFO.
module iir_decimator #(
  parameter int Ndint  = 3,
  parameter int Ndfrac = 22,
  parameter int Noint  = 1,
  parameter int Nofrac = 15,
  parameter int Mdec   = 4,
  parameter int Nfifo  = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          dv_in,
  input  logic signed [Ndint-1:-Ndfrac] d_in,
  input  logic                          phase_clr,
  input  logic                          sat_clr,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic signed [Noint-1:-Nofrac] d_out,
  output logic                          sat_flag,
  output logic [15:0]                   drop_cnt,
  output logic [$clog2(Nfifo):0]        fill
);

  localparam int WS = Ndint + Ndfrac + 1;
  localparam int SH = Ndfrac - Nofrac;
  localparam int WT = WS - SH;
  localparam int WO = Noint + Nofrac;
  localparam int PW = (Mdec > 1) ? $clog2(Mdec) : 1;
  localparam int AW = $clog2(Nfifo);
  localparam int FW = AW + 1;

  localparam logic signed [WS-1:0] HALF = WS'(64'sd1 <<< (SH - 1));
  localparam logic signed [WT-1:0] MAXV = WT'((64'sd1 <<< (WO - 1)) - 64'sd1);
  localparam logic signed [WT-1:0] MINV = WT'(-(64'sd1 <<< (WO - 1)));
  localparam logic [WO-1:0]        MAXO = {1'b0, {(WO-1){1'b1}}};
  localparam logic [WO-1:0]        MINO = {1'b1, {(WO-1){1'b0}}};

  // Clamp a truncated value to the output range; the top result bit flags a clamp.
  function automatic logic [WO:0] clamp_q(input logic signed [WT-1:0] t);
    logic [WO:0] r;
    if (t > MAXV) begin
      r = {1'b1, MAXO};
    end else if (t < MINV) begin
      r = {1'b1, MINO};
    end else begin
      r = {1'b0, t[WO-1:0]};
    end
    return r;
  endfunction

  logic [PW-1:0]        phase_r, eff_phase_s, phase_nxt_s;
  logic                 keep_s;
  logic signed [WS-1:0] d_ext_s;
  logic signed [WS-1:0] s1_r;
  logic                 s1_v_r;
  logic [WO:0]          q_s;
  logic [WO-1:0]        s2_r;
  logic                 s2_v_r;
  logic                 unused_lsb_s;

  logic [WO-1:0]        mem [Nfifo];
  logic [AW-1:0]        wr_ptr_r, rd_ptr_r, rd_nxt_s;
  logic [FW-1:0]        left_s, fill_nxt_s;
  logic                 pop_s, full_s, wr_s, drop_s;
  logic [WO-1:0]        head_s;

  // Effective phase: phase_clr restarts the count so a same-cycle sample is kept.
  always_comb begin
    eff_phase_s = phase_clr ? {PW{1'b0}} : phase_r;
    keep_s      = dv_in && (eff_phase_s == {PW{1'b0}});
    if (dv_in) begin
      if (eff_phase_s == PW'(Mdec - 1)) begin
        phase_nxt_s = {PW{1'b0}};
      end else begin
        phase_nxt_s = eff_phase_s + PW'(1);
      end
    end else begin
      phase_nxt_s = eff_phase_s;
    end
  end

  assign d_ext_s      = {d_in[Ndint-1], d_in};
  assign q_s          = clamp_q(s1_r[WS-1:SH]);
  assign unused_lsb_s = ^s1_r[SH-1:0];

  // FIFO bookkeeping; the output register is the FIFO head and counts toward fill.
  always_comb begin
    pop_s      = out_valid && out_ready;
    full_s     = (fill == FW'(Nfifo));
    wr_s       = s2_v_r && (!full_s || pop_s);
    drop_s     = s2_v_r && full_s && !pop_s;
    rd_nxt_s   = pop_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
    left_s     = fill - FW'(pop_s);
    fill_nxt_s = left_s + FW'(wr_s);
    if (fill_nxt_s == {FW{1'b0}}) begin
      head_s = d_out;
    end else if (left_s == {FW{1'b0}}) begin
      head_s = s2_r;
    end else begin
      head_s = mem[rd_nxt_s];
    end
  end

  // Storage array write; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (resetn && wr_s) begin
      mem[wr_ptr_r] <= s2_r;
    end
  end

  // Phase counter, two-stage requantizer, FIFO state and status outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      phase_r   <= {PW{1'b0}};
      s1_r      <= {WS{1'b0}};
      s1_v_r    <= 1'b0;
      s2_r      <= {WO{1'b0}};
      s2_v_r    <= 1'b0;
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      fill      <= {FW{1'b0}};
      out_valid <= 1'b0;
      d_out     <= {WO{1'b0}};
      sat_flag  <= 1'b0;
      drop_cnt  <= 16'h0000;
    end else begin
      phase_r <= phase_nxt_s;
      s1_v_r  <= keep_s;
      if (keep_s) begin
        s1_r <= d_ext_s + HALF;
      end
      s2_v_r <= s1_v_r;
      if (s1_v_r) begin
        s2_r <= q_s[WO-1:0];
      end
      if (s1_v_r && q_s[WO]) begin
        sat_flag <= 1'b1;
      end else if (sat_clr) begin
        sat_flag <= 1'b0;
      end
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r  <= rd_nxt_s;
      fill      <= fill_nxt_s;
      out_valid <= (fill_nxt_s != {FW{1'b0}});
      d_out     <= head_s;
      if (drop_s && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_iir_decimator.sv
// Three decimator configurations share one stimulus stream; a queue-based model
// predicts every output each cycle and directed sections pin literal results.
module tb_iir_decimator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, dv_in, phase_clr, sat_clr, out_ready;
  logic signed [24:0] d_in;

  logic        ov_a, ov_b, ov_c, sf_a, sf_b, sf_c;
  logic [15:0] dq_a, dq_b, dq_c, dc_a, dc_b, dc_c;
  logic [3:0]  fl_a, fl_b;
  logic [2:0]  fl_c;

  logic        ov [3];
  logic        sf [3];
  logic [15:0] dq [3];
  logic [15:0] dc [3];
  logic [3:0]  fl [3];

  iir_decimator #(.Mdec(4), .Nfifo(8)) dut_a (
    .clk(clk), .resetn(resetn), .dv_in(dv_in), .d_in(d_in), .phase_clr(phase_clr),
    .sat_clr(sat_clr), .out_ready(out_ready), .out_valid(ov_a), .d_out(dq_a),
    .sat_flag(sf_a), .drop_cnt(dc_a), .fill(fl_a));
  iir_decimator #(.Mdec(1), .Nfifo(8)) dut_b (
    .clk(clk), .resetn(resetn), .dv_in(dv_in), .d_in(d_in), .phase_clr(phase_clr),
    .sat_clr(sat_clr), .out_ready(out_ready), .out_valid(ov_b), .d_out(dq_b),
    .sat_flag(sf_b), .drop_cnt(dc_b), .fill(fl_b));
  iir_decimator #(.Mdec(1), .Nfifo(4)) dut_c (
    .clk(clk), .resetn(resetn), .dv_in(dv_in), .d_in(d_in), .phase_clr(phase_clr),
    .sat_clr(sat_clr), .out_ready(out_ready), .out_valid(ov_c), .d_out(dq_c),
    .sat_flag(sf_c), .drop_cnt(dc_c), .fill(fl_c));

  always_comb begin
    ov[0] = ov_a; ov[1] = ov_b; ov[2] = ov_c;
    sf[0] = sf_a; sf[1] = sf_b; sf[2] = sf_c;
    dq[0] = dq_a; dq[1] = dq_b; dq[2] = dq_c;
    dc[0] = dc_a; dc[1] = dc_b; dc[2] = dc_c;
    fl[0] = fl_a; fl[1] = fl_b; fl[2] = {1'b0, fl_c};
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int mdec [3] = '{4, 1, 1};
  int nf   [3] = '{8, 8, 4};
  int mphase [3];
  bit pv   [3][4];
  int pval [3][4];
  bit ps   [3][4];
  int fq   [3][$];
  bit msat [3];
  int mdrop[3];
  int mdo  [3];
  int mcyc = 0;
  bit started = 1'b0;
  int cap  [3][$];

  // Round half up at 2^-15 of a Q3.22 value given in units of 2^-22, then clamp.
  function automatic int rq(input int x, output bit s);
    int t;
    t = (x + 64) >>> 7;
    s = 1'b0;
    if (t > 32767) begin t = 32767; s = 1'b1; end
    else if (t < -32768) begin t = -32768; s = 1'b1; end
    return t & 32'hFFFF;
  endfunction

  task automatic model_step(input int i);
    int ks, ss, ws, eff;
    bit s, pop, full;
    ks = mcyc % 4;
    ss = (mcyc + 3) % 4;
    ws = (mcyc + 2) % 4;
    if (!resetn) begin
      mphase[i] = 0;
      for (int k = 0; k < 4; k++) pv[i][k] = 1'b0;
      fq[i].delete();
      msat[i] = 1'b0;
      mdrop[i] = 0;
      mdo[i] = 0;
    end else begin
      full = (fq[i].size() == nf[i]);
      pop  = (fq[i].size() > 0) && out_ready;
      if (pop) void'(fq[i].pop_front());
      if (pv[i][ws]) begin
        if (full && !pop) begin
          if (mdrop[i] < 65535) mdrop[i]++;
        end else begin
          fq[i].push_back(pval[i][ws]);
        end
      end
      if (pv[i][ss] && ps[i][ss]) msat[i] = 1'b1;
      else if (sat_clr) msat[i] = 1'b0;
      eff = phase_clr ? 0 : mphase[i];
      if (dv_in && eff == 0) begin
        pval[i][ks] = rq(int'(d_in), s);
        ps[i][ks] = s;
        pv[i][ks] = 1'b1;
      end else begin
        pv[i][ks] = 1'b0;
      end
      mphase[i] = dv_in ? (eff + 1) % mdec[i] : eff;
      if (fq[i].size() > 0) mdo[i] = fq[i][0];
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) model_step(i);
    mcyc++;
    started = 1'b1;
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("out_valid[%0d]", i), int'(ov[i]), int'(fq[i].size() > 0));
        chk($sformatf("d_out[%0d]", i), int'(dq[i]), mdo[i]);
        chk($sformatf("fill[%0d]", i), int'(fl[i]), fq[i].size());
        chk($sformatf("drop_cnt[%0d]", i), int'(dc[i]), mdrop[i]);
        chk($sformatf("sat_flag[%0d]", i), int'(sf[i]), int'(msat[i]));
        if (ov[i] && out_ready) cap[i].push_back(int'(dq[i]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic put(input logic dv, input int d, input logic pc = 1'b0, input logic sc = 1'b0);
    @(posedge clk);
    #1;
    dv_in = dv;
    d_in = d[24:0];
    phase_clr = pc;
    sat_clr = sc;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) put(1'b0, 0);
  endtask

  task automatic check_cap(input int i, input string nm, input int n,
                           input int e0, input int e1 = 0, input int e2 = 0,
                           input int e3 = 0, input int e4 = 0);
    int e[5];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
    chk({nm, "_count"}, cap[i].size(), n);
    for (int j = 0; j < n; j++)
      chk($sformatf("%s_%0d", nm, j), (j < cap[i].size()) ? cap[i][j] : -1, e[j]);
  endtask

  initial begin
    int r;
    resetn = 1'b0; dv_in = 1'b0; d_in = '0; phase_clr = 1'b0; sat_clr = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(ov_a), 0);
    chk("rst_fill", int'(fl_a), 0);
    chk("rst_dout", int'(dq_a), 0);
    chk("rst_drop", int'(dc_a), 0);
    chk("rst_sat", int'(sf_a), 0);
    resetn = 1'b1;

    // Mdec=4 ramp k/64: kept k=0,4,8,12; output three cycles after the first sample.
    cap[0].delete();
    for (int k = 0; k < 16; k++) begin
      put(1'b1, k * 65536);
      if (k == 2) chk("lat_early", int'(ov_a), 0);
      if (k == 3) chk("lat_first", int'(ov_a), 1);
    end
    put(1'b0, 0);
    idle(6);
    check_cap(0, "ramp", 4, 'h0000, 'h0800, 'h1000, 'h1800);
    chk("ramp_drop", int'(dc_a), 0);

    // Rounding around +-2^-16 with Mdec=1.
    cap[1].delete();
    put(1'b1, 64); put(1'b1, 63); put(1'b1, -64); put(1'b1, -65);
    put(1'b0, 0);
    idle(6);
    check_cap(1, "round", 4, 'h0001, 'h0000, 'h0000, 'hFFFF);
    chk("round_sat", int'(sf_b), 0);

    // Saturation: +1.5, round overflow at 1-2^-17, -3.0.
    cap[1].delete();
    put(1'b1, 6291456); put(1'b1, 4194272); put(1'b1, -12582912);
    put(1'b0, 0);
    idle(4);
    chk("sat_set", int'(sf_b), 1);
    check_cap(1, "sat", 3, 'h7FFF, 'h7FFF, 'h8000);
    put(1'b0, 0, 1'b0, 1'b1);
    put(1'b0, 0);
    chk("sat_clr_alone", int'(sf_b), 0);
    put(1'b1, -12582912);
    put(1'b0, 0, 1'b0, 1'b1);
    put(1'b0, 0);
    chk("sat_set_wins", int'(sf_b), 1);

    // Nfifo=4 overflow and ordered drain.
    idle(4);
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) put(1'b1, k * 128);
    put(1'b0, 0);
    idle(3);
    chk("ovf_fill", int'(fl_c), 4);
    chk("ovf_drop", int'(dc_c), 2);
    chk("ovf_head", int'(dq_c), 'h0001);
    idle(2);
    chk("ovf_hold", int'(dq_c), 'h0001);
    chk("ovf_hold_v", int'(ov_c), 1);
    out_ready = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      put(1'b0, 0);
      chk($sformatf("drain_%0d", k), int'(dq_c), k);
    end
    put(1'b0, 0);
    chk("drain_empty", int'(ov_c), 0);

    // Reset with three buffered samples and two in flight.
    idle(10);
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) put(1'b1, k * 128);
    put(1'b0, 0);
    chk("pre_rst_fill", int'(fl_b), 3);
    resetn = 1'b0;
    dv_in = 1'b1;
    d_in = 25'd1024;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    dv_in = 1'b0;
    chk("mid_rst_valid", int'(ov_b), 0);
    chk("mid_rst_fill", int'(fl_b), 0);
    chk("mid_rst_drop", int'(dc_c), 0);
    chk("mid_rst_sat", int'(sf_b), 0);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      put(1'b0, 0);
      chk("no_stale", int'(ov_b), 0);
    end
    put(1'b1, 7 * 128);
    put(1'b0, 0);
    put(1'b0, 0);
    chk("post_rst_early", int'(ov_b), 0);
    put(1'b0, 0);
    chk("post_rst_valid", int'(ov_b), 1);
    chk("post_rst_data", int'(dq_b), 7);

    // phase_clr on index 6 with Mdec=4.
    idle(4);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    idle(2);
    cap[0].delete();
    for (int k = 0; k < 16; k++) put(1'b1, k * 128, (k == 6));
    put(1'b0, 0);
    idle(8);
    check_cap(0, "phase_clr", 5, 0, 4, 6, 10, 14);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk);
      #1;
      case ($urandom_range(0, 3))
        0, 1: r = int'($urandom);
        2: r = int'($urandom_range(0, 600)) - 300;
        default: r = ($urandom_range(0, 1) ? 4194304 : -4194304) + int'($urandom_range(0, 400)) - 200;
      endcase
      d_in = r[24:0];
      dv_in = ($urandom_range(0, 3) != 0);
      phase_clr = ($urandom_range(0, 15) == 0);
      sat_clr = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      resetn = ($urandom_range(0, 299) != 0);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    out_ready = 1'b1;
    dv_in = 1'b0;
    phase_clr = 1'b0;
    sat_clr = 1'b0;
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
